// File: rtl/pixel_pair_fetcher.sv
// rtl/pixel_pair_fetcher.sv - dual frame-buffer pixel pair reader with 2-entry credited output buffer
module pixel_pair_fetcher #(
  parameter int PIXEL_W = 24,
  parameter int ADDR_W  = 16,
  parameter int OP_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OP_W-1:0]    job_opcode,
  input  logic [ADDR_W-1:0]  base_a,
  input  logic [ADDR_W-1:0]  base_b,
  input  logic [ADDR_W-1:0]  num_pixels,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr_a,
  output logic [ADDR_W-1:0]  mem_addr_b,
  input  logic [PIXEL_W-1:0] mem_data_a,
  input  logic [PIXEL_W-1:0] mem_data_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] pixel_a,
  output logic [PIXEL_W-1:0] pixel_b,
  output logic [OP_W-1:0]    opcode,
  output logic               out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   base_a_q, base_b_q, num_q, issued, out_idx;
  logic                inflight;
  logic [PIXEL_W-1:0]  fifo_a [2];
  logic [PIXEL_W-1:0]  fifo_b [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          fifo_count;
  logic                fifo_empty, push, pop, rd_issue, last_issue, drained;
  logic [2:0]          credit;

  // Occupancy the FIFO would reach if a read issued now, counting the read already in flight.
  assign fifo_empty = (fifo_count == 2'd0);
  assign push       = inflight;
  assign pop        = !fifo_empty && out_ready;
  assign credit     = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign rd_issue   = (state == FETCH) && (issued < num_q) && (credit < 3'd2);
  assign last_issue = rd_issue && (issued == num_q - ADDR_W'(1));
  // Looks one cycle ahead so done lands in the cycle right after the final pop.
  assign drained    = !inflight && (fifo_empty || (fifo_count == 2'd1 && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_pixels == '0) ? DONE : FETCH;
      FETCH:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == FETCH) || (state == DRAIN);
    done       = (state == DONE);
    mem_rd_en  = rd_issue;
    mem_addr_a = rd_issue ? base_a_q + issued : '0;
    mem_addr_b = rd_issue ? base_b_q + issued : '0;
    out_valid  = !fifo_empty;
    pixel_a    = out_valid ? fifo_a[rd_ptr] : '0;
    pixel_b    = out_valid ? fifo_b[rd_ptr] : '0;
    out_last   = out_valid && (out_idx == num_q - ADDR_W'(1));
    opcode     = op_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      num_q      <= '0;
      issued     <= '0;
      out_idx    <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (state == IDLE && start) begin
        op_q     <= job_opcode;
        base_a_q <= base_a;
        base_b_q <= base_b;
        num_q    <= num_pixels;
        issued   <= '0;
        out_idx  <= '0;
      end else begin
        if (rd_issue) issued  <= issued + ADDR_W'(1);
        if (pop)      out_idx <= out_idx + ADDR_W'(1);
      end
      inflight <= rd_issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= mem_data_a;
      fifo_b[wr_ptr] <= mem_data_b;
    end
  end

endmodule

// File: tb/tb_pixel_pair_fetcher.sv
// tb/tb_pixel_pair_fetcher.sv - scoreboard bench for pixel_pair_fetcher
module tb_pixel_pair_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  job_opcode = '0;
  logic [15:0] base_a = '0, base_b = '0, num_pixels = '0;
  logic        busy, done, mem_rd_en, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic [23:0] mem_data_a = '0, mem_data_b = '0, pixel_a, pixel_b;
  logic [3:0]  opcode;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  pixel_pair_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .job_opcode(job_opcode),
    .base_a(base_a), .base_b(base_b), .num_pixels(num_pixels),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .pixel_a(pixel_a), .pixel_b(pixel_b), .opcode(opcode), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Frame buffers return their own address; non-read cycles return junk.
  always @(posedge clk) begin
    mem_data_a <= mem_rd_en ? {8'h00, mem_addr_a} : 24'hBAD0A0;
    mem_data_b <= mem_rd_en ? {8'h00, mem_addr_b} : 24'hBAD0B0;
  end

  function automatic logic [63:0] pack(input logic [23:0] pa, input logic [23:0] pb,
                                       input logic [3:0] op, input logic last);
    return {11'b0, pa, pb, op, last};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic        stalled;
    logic [63:0] held, cur;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = pack(pixel_a, pixel_b, opcode, out_last);
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) check("hold", {out_valid, cur[62:0]}, {1'b1, held[62:0]});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tuple: got %h expected none", cur);
          end else check("tuple", cur, sb.pop_front());
        end
        stalled = out_valid && !out_ready;
        held = cur;
      end
    end
  end

  // Leaves the caller #1 after the edge that starts cycle 1.
  task automatic start_job(input logic [3:0] op, input logic [15:0] ba, input logic [15:0] bb,
                           input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; job_opcode = op; base_a = ba; base_b = bb; num_pixels = n;
    for (int i = 0; i < n; i++)
      sb.push_back(pack({8'h00, 16'(ba + 16'(i))}, {8'h00, 16'(bb + 16'(i))}, op, i == n - 1));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  initial begin
    int cyc, reads, n;
    logic [15:0] wrap_exp [4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Reset state
    #2;
    check("reset_outputs", {busy, done, mem_rd_en, mem_addr_a, mem_addr_b, out_valid,
                            pixel_a, pixel_b, opcode, out_last}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic job with latency checks
    start_job(4'd3, 16'h0100, 16'h0200, 16'd4);
    @(negedge clk);
    check("basic_c1_rd_busy", {mem_rd_en, busy, mem_addr_a, mem_addr_b}, {2'b11, 16'h0100, 16'h0200});
    @(negedge clk);
    check("basic_c2_no_valid", out_valid, 1'b0);
    @(negedge clk);
    check("basic_c3_valid", out_valid, 1'b1);
    wait_done(cyc);
    check("basic_done_cycle", 3 + cyc, 7);
    check("basic_done_busy", {busy, sb.size() == 0}, 2'b01);
    @(negedge clk);
    check("basic_done_pulse", done, 1'b0);

    // Backpressure: out_ready low in cycles 2-9
    start_job(4'd3, 16'h0100, 16'h0200, 16'd4);
    reads = 0;
    @(negedge clk);
    if (mem_rd_en) reads++;
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      if (mem_rd_en) reads++;
    end
    check("bp_reads_before_pop", reads, 2);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(cyc);
    check("bp_done_after_last", {out_valid, sb.size() == 0}, 2'b01);

    // Zero-length job
    start_job(4'd7, 16'h1000, 16'h2000, 16'd0);
    @(negedge clk);
    check("zero_c1", {done, busy, mem_rd_en, out_valid}, 4'b1000);
    @(negedge clk);
    check("zero_c2", {done, busy, mem_rd_en, out_valid}, 4'b0000);

    // Address wrap
    start_job(4'd1, 16'hFFFE, 16'h0010, 16'd4);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      if (mem_rd_en) begin
        if (n < 4) check("wrap_addr_a", mem_addr_a, wrap_exp[n]);
        n++;
      end
      if (done) break;
    end
    check("wrap_read_count", n, 4);

    // Second start while busy is ignored
    start_job(4'd5, 16'h0300, 16'h0400, 16'd3);
    start = 1'b1; job_opcode = 4'd9; base_a = 16'h0500; base_b = 16'h0600; num_pixels = 16'd7;
    @(posedge clk); #1 start = 1'b0;
    wait_done(cyc);
    check("busy_start_ignored", {sb.size() == 0, out_valid}, 2'b10);
    @(negedge clk);
    check("busy_start_no_restart", {busy, mem_rd_en}, 2'b00);

    // Reset mid-job after two pops with a read in flight
    start_job(4'd2, 16'h0600, 16'h0700, 16'd8);
    repeat (4) @(posedge clk);
    #1;
    check("mid_pops_done", sb.size(), 6);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {busy, done, mem_rd_en, mem_addr_a, mem_addr_b, out_valid,
                                pixel_a, pixel_b, opcode, out_last}, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    reads = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid || mem_rd_en || busy) reads++;
    end
    check("post_reset_idle", reads, 0);
    start_job(4'd6, 16'h0800, 16'h0900, 16'd2);
    @(negedge clk);
    check("post_reset_rd", {mem_rd_en, mem_addr_a}, {1'b1, 16'h0800});
    wait_done(cyc);
    check("post_reset_done", 1 + cyc, 5);
    check("post_reset_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pixel_pair_fetcher.md
Name: pixel_pair_fetcher

Overview:
Front-end feeder for the image processor datapath. It takes a job descriptor (two source image base addresses, a pixel count and an opcode) and reads the matching pixels from two synchronous frame-buffer ports. It then streams (pixelA, pixelB, opcode) tuples to the processor over a valid/ready handshake. A 2-entry output buffer with read-credit accounting lets the block absorb backpressure without dropping memory data.

Parameters:
PIXEL_W, 24, width of one pixel (8-bit R,G,B packed)
ADDR_W, 16, frame-buffer address width; also the width of the pixel count
OP_W, 4, opcode width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  job request, sampled only in IDLE
job_opcode  in  OP_W  opcode for the job, latched at start
base_a  in  ADDR_W  image A start address, latched at start
base_b  in  ADDR_W  image B start address, latched at start
num_pixels  in  ADDR_W  pixel pairs in the job, latched at start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end
mem_rd_en  out  1  read strobe for both frame-buffer ports
mem_addr_a  out  ADDR_W  image A read address
mem_addr_b  out  ADDR_W  image B read address
mem_data_a  in  PIXEL_W  image A read data, valid exactly 1 cycle after mem_rd_en
mem_data_b  in  PIXEL_W  image B read data, same timing as mem_data_a
out_valid  out  1  output tuple valid
out_ready  in  1  processor accepts the tuple
pixel_a  out  PIXEL_W  pixel from image A
pixel_b  out  PIXEL_W  pixel from image B
opcode  out  OP_W  latched job opcode
out_last  out  1  marks the final tuple of the job

Behaviour:
- Reset (async, any state): state=IDLE; all counters, FIFO and in-flight tracking cleared. All outputs 0. Any memory data returning after reset is ignored.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 latches job_opcode, base_a, base_b and num_pixels, and clears the issue index.
  - num_pixels!=0 -> FETCH.
  - num_pixels==0 -> DONE; no reads are issued and no tuples are produced.
- start is ignored in every state except IDLE.
- FETCH read issue rule: mem_rd_en=1 when issued < num_pixels AND (fifo_count + inflight - pop) < 2.
  - pop = out_valid & out_ready.
  - inflight = 1 if mem_rd_en was high in the previous cycle, else 0.
- Read addresses: mem_addr_a = base_a + issued and mem_addr_b = base_b + issued, each modulo 2^ADDR_W (wrap-around is allowed). issued increments on every issued read.
- After the last read is issued -> DRAIN.
- Return path: data returning 1 cycle after mem_rd_en is written into a 2-entry FIFO as {mem_data_a, mem_data_b}. The FIFO head drives pixel_a and pixel_b. out_valid = FIFO not empty. The credit rule guarantees the FIFO never overflows; a push and a pop in the same cycle are allowed.
- opcode is held at the latched value for the whole job. out_last=1 on the tuple whose index equals num_pixels-1 (counted at the output).
- Output rules: pixel_a, pixel_b and out_last hold stable while out_valid=1 and out_ready=0. out_valid never drops without a pop.
- DRAIN -> DONE when the FIFO is empty and inflight==0.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE. A start in DONE is ignored.
- busy=1 in FETCH and DRAIN.
- Latency with out_ready=1:
  - start in cycle 0.
  - mem_rd_en first high in cycle 1.
  - out_valid first high in cycle 3.
  - One tuple per cycle sustained afterwards.
  - done in the cycle after the last pop.

Test Plan:
- Basic job: base_a=0x0100, base_b=0x0200, num_pixels=4, opcode=3, out_ready=1, memory returns data=address -> tuples (0x100,0x200)…(0x103,0x203) in cycles 3-6, opcode=3 throughout, out_last only on the 4th tuple, done pulses in cycle 7.
- Backpressure: same job with out_ready=0 for cycles 2-9 -> at most 2 reads issued before the first pop, the head tuple holds stable, no data is lost, all 4 tuples arrive in order, done follows the last pop.
- Zero-length job: num_pixels=0 -> mem_rd_en never asserts, out_valid never asserts, done pulses 1 cycle after start.
- Address wrap: base_a=0xFFFE, num_pixels=4 -> mem_addr_a sequence FFFE, FFFF, 0000, 0001.
- start while busy: a second start during FETCH with different bases -> ignored; the job completes with the original parameters.
- Reset mid-job: assert rst during FETCH after 2 pops with a read in flight -> all outputs 0 immediately, the FIFO is empty after release. A new start yields a clean job with no stale tuples.
